fetch_sequencer: RTL and testbench

Front-end fetch controller for the 4-wide InstructionCache. Each cycle it can issue one 4-instruction bundle: it generates four consecutive 15-bit word PCs, tracks the cache's 1-cycle read latency, and buffers returned bundles in a small queue with a valid/ready handshake to decode. Redirects from branch resolution flush in-flight and queued bundles and restart fetch at a new PC.

---
 rtl/fetch_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Front-end fetch controller for the 4-wide instruction cache. Each cycle it
//   may issue one 4-word bundle read, follows the cache's 1-cycle read latency
//   and buffers the returned bundles in a small queue towards decode, which
//   uses a valid/ready handshake. A redirect flushes everything in flight and
//   restarts fetch at a new word address.
//
// Ports
//   clk                clock, every state update on its rising edge
//   rst                synchronous active-high reset (wins over redirect)
//   pc_array_flat      cache address, slot0 [59:45] .. slot3 [14:0]
//   instructions_flat  cache data, one cycle after the address, slot0 [63:48]
//   redirect_valid     restart fetch at redirect_pc
//   redirect_pc        word address of the new fetch start
//   out_valid          queue head valid
//   out_ready          decode accepts the head when out_valid & out_ready
//   out_instructions   head bundle, same slot packing as instructions_flat
//   out_pc             word address of the head's slot0
module fetch_sequencer #(
  parameter logic [14:0] RESET_PC    = 15'h0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [59:0] pc_array_flat,
  input  logic [63:0] instructions_flat,
  input  logic        redirect_valid,
  input  logic [14:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_instructions,
  output logic [14:0] out_pc
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(QUEUE_DEPTH);

  // Fetch-side state
  logic [14:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [14:0]      issue_pc_q, issue_pc_d;

  // Bundle queue state
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [63:0]      q_data_q [QUEUE_DEPTH];
  logic [63:0]      q_data_d [QUEUE_DEPTH];
  logic [14:0]      q_pc_q   [QUEUE_DEPTH];
  logic [14:0]      q_pc_d   [QUEUE_DEPTH];

  // Handshake / control
  logic             deq;
  logic             enq;
  logic             issue;
  logic [OCC_W-1:0] occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  // Occupancy counts queued bundles plus the one returning next edge, minus the
  // one leaving this cycle. Issuing only while it is below the depth guarantees
  // every return finds a free slot, so no return ever needs to be stalled.
  always_comb begin
    deq       = out_valid & out_ready;
    enq       = inflight_q & ~rst & ~redirect_valid;
    occupancy = {1'b0, count_q} + OCC_W'(inflight_q) - OCC_W'(deq);
    issue     = ~rst & ~redirect_valid & (occupancy < OCC_LIMIT);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      issue_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      issue_pc_q <= issue_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    q_data_q <= q_data_d;
    q_pc_q   <= q_pc_d;
  end

  // The issue rule makes an enqueue into a full queue impossible.
  always_ff @(posedge clk) begin
    if (enq && !deq) begin
      assert (count_q != CNT_FULL)
        else $error("fetch_sequencer: bundle queue overflow");
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    issue_pc_d = issue_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    q_data_d   = q_data_q;
    q_pc_d     = q_pc_q;

    if (rst) begin
      fetch_pc_d = RESET_PC;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else if (redirect_valid) begin
      // Flush: the queue empties and inflight_d stays 0, so whatever the cache
      // returns next cycle is ignored.
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 15'd4;
        inflight_d = 1'b1;
        issue_pc_d = fetch_pc_q;
      end
      if (enq) begin
        q_data_d[wr_ptr_q] = instructions_flat;
        q_pc_d[wr_ptr_q]   = issue_pc_q;
        wr_ptr_d           = ptr_inc(wr_ptr_q);
      end
      if (deq) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Each slot wraps mod 2^15 on its own, so a bundle may straddle 7FFF->0000.
  always_comb begin
    pc_array_flat    = {fetch_pc_q,
                        fetch_pc_q + 15'd1,
                        fetch_pc_q + 15'd2,
                        fetch_pc_q + 15'd3};
    out_valid        = (count_q != '0);
    out_instructions = q_data_q[rd_ptr_q];
    out_pc           = q_pc_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [59:0] pc_array_flat;
  logic [63:0] instructions_flat;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_instructions;
  logic [14:0] out_pc;

  int n_checks;
  int n_fail;
  logic [15:0] mem_xor;

  fetch_sequencer #(.RESET_PC(15'h0000), .QUEUE_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_array_flat     (pc_array_flat),
    .instructions_flat (instructions_flat),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_instructions  (out_instructions),
    .out_pc            (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word k holds k ^ mem_xor.
  function automatic logic [15:0] mem_word(input logic [14:0] a);
    return {1'b0, a} ^ mem_xor;
  endfunction

  // Instruction cache: one-cycle read latency, reads every cycle.
  always @(posedge clk) begin
    instructions_flat <= {mem_word(pc_array_flat[59:45]), mem_word(pc_array_flat[44:30]),
                          mem_word(pc_array_flat[29:15]), mem_word(pc_array_flat[14:0])};
  end

  function automatic logic [59:0] slots(input logic [14:0] p);
    return {p, p + 15'd1, p + 15'd2, p + 15'd3};
  endfunction

  function automatic logic [63:0] bundle(input logic [14:0] p);
    return {mem_word(p), mem_word(p + 15'd1), mem_word(p + 15'd2), mem_word(p + 15'd3)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [14:0] rpc;
    logic        rdy;
    logic        ev;
    logic [14:0] epc;
    logic [14:0] eslot;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  task automatic set_vec(input int i, input logic r, input logic rv, input logic [14:0] rpc,
                         input logic rdy, input logic ev, input logic [14:0] epc,
                         input logic [14:0] eslot);
    vecs[i].rst   = r;
    vecs[i].rv    = rv;
    vecs[i].rpc   = rpc;
    vecs[i].rdy   = rdy;
    vecs[i].ev    = ev;
    vecs[i].epc   = epc;
    vecs[i].eslot = eslot;
  endtask

  initial begin
    int          zero_left;
    logic [14:0] exp_pc;
    logic        rv;
    logic        rdy;
    logic [14:0] rpc;
    logic        prev_rv;
    logic [14:0] prev_rpc;

    n_checks = 0;
    n_fail   = 0;
    mem_xor  = 16'h0000;

    // Inputs applied in a cycle and outputs expected in that same cycle.
    //            rst rv  rpc       rdy ev  epc       slot0
    set_vec( 0, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0000);
    set_vec( 1, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0004);
    set_vec( 2, 0, 0, 15'h0000, 1, 1, 15'h0000, 15'h0008);
    set_vec( 3, 0, 0, 15'h0000, 1, 1, 15'h0004, 15'h000C);
    set_vec( 4, 0, 0, 15'h0000, 1, 1, 15'h0008, 15'h0010);
    set_vec( 5, 0, 0, 15'h0000, 1, 1, 15'h000C, 15'h0014);
    set_vec( 6, 1, 1, 15'h0100, 1, 1, 15'h0010, 15'h0018); // reset beats redirect
    set_vec( 7, 0, 0, 15'h0000, 0, 0, 15'h0000, 15'h0000);
    set_vec( 8, 0, 0, 15'h0000, 0, 0, 15'h0000, 15'h0004);
    set_vec( 9, 0, 0, 15'h0000, 0, 1, 15'h0000, 15'h0008); // backpressure: queue fills
    set_vec(10, 0, 0, 15'h0000, 0, 1, 15'h0000, 15'h0008);
    set_vec(11, 0, 0, 15'h0000, 0, 1, 15'h0000, 15'h0008);
    set_vec(12, 0, 0, 15'h0000, 1, 1, 15'h0000, 15'h0008);
    set_vec(13, 0, 0, 15'h0000, 1, 1, 15'h0004, 15'h000C);
    set_vec(14, 0, 0, 15'h0000, 1, 1, 15'h0008, 15'h0010);
    set_vec(15, 0, 0, 15'h0000, 0, 1, 15'h000C, 15'h0014);
    set_vec(16, 0, 1, 15'h0100, 0, 1, 15'h000C, 15'h0014); // redirect with full queue
    set_vec(17, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0100);
    set_vec(18, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0104);
    set_vec(19, 0, 0, 15'h0000, 1, 1, 15'h0100, 15'h0108);
    set_vec(20, 0, 1, 15'h7FFE, 1, 1, 15'h0104, 15'h010C); // redirect + deq + inflight
    set_vec(21, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h7FFE);
    set_vec(22, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0002);
    set_vec(23, 0, 0, 15'h0000, 1, 1, 15'h7FFE, 15'h0006); // wrapped bundle
    set_vec(24, 0, 0, 15'h0000, 1, 1, 15'h0002, 15'h000A);
    set_vec(25, 0, 1, 15'h0200, 1, 1, 15'h0006, 15'h000E); // redirect held two cycles
    set_vec(26, 0, 1, 15'h0300, 1, 0, 15'h0000, 15'h0200);
    set_vec(27, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0300);
    set_vec(28, 0, 0, 15'h0000, 1, 0, 15'h0000, 15'h0304);
    set_vec(29, 0, 0, 15'h0000, 1, 1, 15'h0300, 15'h0308);
    set_vec(30, 0, 0, 15'h0000, 1, 1, 15'h0304, 15'h030C);

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 15'h0000;
    out_ready      = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d pc_array", i), 64'(pc_array_flat), 64'(slots(vecs[i].eslot)));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d out_pc", i), 64'(out_pc), 64'(vecs[i].epc));
        check($sformatf("vec%0d out_instr", i), out_instructions, bundle(vecs[i].epc));
      end
      rst            = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
    end

    // Randomised phase. Reference rules: after reset release or a redirect the
    // queue is empty for two cycles, then (depth 2) never runs dry again until
    // the next flush; the head is always the next expected bundle and advances
    // by 4 on each accepted handshake.
    @(posedge clk);
    #1;
    mem_xor        = 16'h5A5A;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    zero_left = 2;
    exp_pc    = 15'h0000;
    prev_rv   = 1'b0;
    prev_rpc  = 15'h0000;

    for (int t = 0; t < 1000; t++) begin
      if (prev_rv)
        check($sformatf("rand%0d redirect slots", t), 64'(pc_array_flat), 64'(slots(prev_rpc)));
      if (zero_left > 0) begin
        check($sformatf("rand%0d flush out_valid", t), 64'(out_valid), 64'd0);
        zero_left--;
      end else begin
        check($sformatf("rand%0d steady out_valid", t), 64'(out_valid), 64'd1);
      end
      if (out_valid) begin
        check($sformatf("rand%0d out_pc", t), 64'(out_pc), 64'(exp_pc));
        check($sformatf("rand%0d out_instr", t), out_instructions, bundle(exp_pc));
      end

      rdy = ($urandom_range(0, 2) != 0);
      rv  = (prev_rv && $urandom_range(0, 2) == 0) || ($urandom_range(0, 39) == 0);
      rpc = 15'($urandom);
      if ($urandom_range(0, 3) == 0) rpc = 15'h7FF8 + 15'($urandom_range(0, 7));

      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;

      if (out_valid && rdy) exp_pc = exp_pc + 15'd4;
      if (rv) begin
        exp_pc    = rpc;
        zero_left = 2;
      end
      prev_rv  = rv;
      prev_rpc = rpc;

      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
